// File: rtl/bram_rd_streamer.sv
// rtl/bram_rd_streamer.sv - burst read master for a 2-cycle-latency BRAM port with a valid/ready output stream
//
// Accepts (addr, len) burst commands and issues one BRAM read per cycle.
// A 2-stage tag pipe tracks the read latency. Returned words land in a
// small output FIFO, which drives the m_* stream.
// Optional macro BRAM_RD_STALL_CNT_EN enables the output stall counter.
// When the macro is undefined, stall_cnt is tied to 0.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   cmd_valid/ready/addr/len  burst command handshake (ready only in IDLE)
//   mem_en/we/addr, mem_rdata BRAM port (read-only use, we tied low)
//   m_valid/ready/data/last   output beat stream
//   busy, done                state != IDLE, one-cycle completion pulse
//   stall_cnt                 cycles with m_valid & !m_ready (optional)

module bram_rd_streamer #(
  parameter int DATA_WIDTH = 96,
  parameter int ADDR_WIDTH = 10,
  parameter int LEN_WIDTH  = 11,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [DATA_WIDTH-1:0] m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           stall_cnt
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  remain_q, remain_d;
  logic [1:0]            tag_q;       // read-in-flight valid per latency stage
  logic [1:0]            tag_last_q;  // matching last-beat flag per stage
  logic                  done_q;

  logic [DATA_WIDTH:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]         count_q, count_d;

  logic                  accept, issue, issue_last, credit, push, pop;
  logic [CW-1:0]         inflight;

  assign accept   = cmd_valid && (state_q == S_IDLE);
  assign inflight = CW'(tag_q[0]) + CW'(tag_q[1]);
  // Credit uses the registered count only; a same-cycle pop is not credited.
  assign credit   = (count_q + inflight) < DEPTH_C;
  assign push     = tag_q[1];
  assign pop      = m_valid && m_ready;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    remain_d   = remain_q;
    issue      = 1'b0;
    issue_last = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (cmd_len == '0) begin
            state_d = S_DONE;
          end else begin
            addr_d   = cmd_addr;
            remain_d = cmd_len;
            state_d  = S_ISSUE;
          end
        end
      end
      S_ISSUE: begin
        // Without credit the cycle is a bubble: address holds, no tag.
        if (credit) begin
          issue    = 1'b1;
          remain_d = remain_q - LEN_WIDTH'(1);
          if (remain_q == LEN_WIDTH'(1)) begin
            issue_last = 1'b1;
            state_d    = S_DRAIN;
          end else begin
            addr_d = addr_q + ADDR_WIDTH'(1);
          end
        end
      end
      S_DRAIN: begin
        if ((tag_q == 2'b00) && (count_q == '0)) state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      remain_q   <= '0;
      tag_q      <= '0;
      tag_last_q <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      remain_q <= remain_d;
      done_q   <= (state_q == S_DONE);
      if (state_q != S_IDLE) begin
        tag_q      <= {tag_q[0], issue};
        tag_last_q <= {tag_last_q[0], issue_last};
      end
    end
  end

  assign count_d = count_q + CW'(push) - CW'(pop);

  // Output FIFO; the credit rule guarantees push never hits a full FIFO.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        fifo_q[wr_ptr_q] <= {tag_last_q[1], mem_rdata};
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);
  assign done      = done_q;
  // Enable stays high through bubbles and drain so the BRAM pipe keeps moving.
  assign mem_en    = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign mem_we    = 1'b0;
  assign mem_addr  = addr_q;
  assign m_valid   = (count_q != '0);
  assign m_data    = fifo_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign m_last    = fifo_q[rd_ptr_q][DATA_WIDTH];

`ifdef BRAM_RD_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_q <= '0;
    end else if (accept) begin
      stall_q <= '0;
    end else if (m_valid && !m_ready && (stall_q != 16'hFFFF)) begin
      stall_q <= stall_q + 16'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_bram_rd_streamer.sv
// tb/tb_bram_rd_streamer.sv - scoreboard bench for bram_rd_streamer with a 2-cycle BRAM model

module tb_bram_rd_streamer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [9:0]  cmd_addr = '0;
  logic [10:0] cmd_len = '0;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [95:0] mem_rdata = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [95:0] m_data;
  logic        m_last;
  logic        busy, done;
  logic [15:0] stall_cnt;

  bram_rd_streamer dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last),
    .busy(busy), .done(done), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail = 0;
  int beat_cnt = 0, last_cnt = 0, done_cnt = 0, stall_seen = 0;
  int cyc = 0, first_cyc = 0, last_cyc = 0;
  logic [96:0] expq [$];

  function automatic logic [95:0] word(input logic [9:0] a);
    logic [31:0] x;
    x = {22'd0, a};
    return {x * 32'h9E3779B1, x ^ 32'hDEADBEEF, x + 32'h0BADF00D};
  endfunction

  // BRAM model: two registered stages, both advancing only when enabled.
  logic [95:0] bram_s1 = '0;
  always @(posedge clk) begin
    if (mem_en) begin
      bram_s1   <= word(mem_addr);
      mem_rdata <= bram_s1;
    end
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Output monitor: scoreboard pops, stall stability, pulse counting.
  logic        prev_stall = 1'b0;
  logic [95:0] prev_data = '0;
  logic        prev_last = 1'b0;
  always @(negedge clk) begin
    logic [96:0] e;
    cyc++;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      chk("fifo_count_bound", 128'(dut.count_q <= 3'd4), 1);
      if (prev_stall) begin
        chk("stall_hold_valid", m_valid, 1);
        chk("stall_hold_data", m_data, prev_data);
        chk("stall_hold_last", m_last, prev_last);
      end
      if (m_valid && m_ready) begin
        chk("beat_expected", 128'(expq.size() != 0), 1);
        if (expq.size() != 0) begin
          e = expq.pop_front();
          chk("beat_data", m_data, e[95:0]);
          chk("beat_last", m_last, e[96]);
        end
        beat_cnt++;
        if (m_last) last_cnt++;
        if (beat_cnt == 1) first_cyc = cyc;
        last_cyc = cyc;
      end
      if (m_valid && !m_ready) stall_seen++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
      if (done) done_cnt++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_cmd(input logic [9:0] a, input logic [10:0] len);
    logic [9:0] ai;
    logic       lb;
    beat_cnt = 0;
    last_cnt = 0;
    stall_seen = 0;
    for (int i = 0; i < int'(len); i++) begin
      ai = a + 10'(i);
      lb = (i == int'(len) - 1);
      expq.push_back({lb, word(ai)});
    end
    chk("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_len   = len;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int d0, input int budget);
    int c = 0;
    while (done_cnt == d0 && c < budget) begin
      step();
      c++;
    end
    chk("done_within_budget", 128'(done_cnt != d0), 1);
    repeat (3) step();
    chk("done_single_pulse", done_cnt - d0, 1);
    chk("idle_after_done", busy, 0);
    chk("queue_drained", expq.size(), 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn, lat, c, dc, lc;
    logic pat [4];
    pat = '{1'b1, 1'b0, 1'b0, 1'b1};

    // Reset values
    repeat (3) step();
    chk("rst_mem_en", mem_en, 0);
    chk("rst_mem_we", mem_we, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_last", m_last, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_stall_cnt", stall_cnt, 0);
    rst = 1'b0;
    step();
    chk("cmd_ready_after_rst", cmd_ready, 1);

    // Burst of 8 from 0x010, consumer always ready
    m_ready = 1'b1;
    dn = done_cnt;
    send_cmd(10'h010, 11'd8);
    chk("t1_mem_en", mem_en, 1);
    chk("t1_first_addr", mem_addr, 10'h010);
    chk("t1_busy", busy, 1);
    lat = 0;
    while (!m_valid && lat < 10) begin
      step();
      lat++;
    end
    chk("t1_first_valid_latency", lat, 3);
    wait_done(dn, 50);
    chk("t1_beats", beat_cnt, 8);
    chk("t1_last_count", last_cnt, 1);
    chk("t1_back_to_back", last_cyc - first_cyc, 7);

    // Address wrap 0x3FE..0x001
    dn = done_cnt;
    send_cmd(10'h3FE, 11'd4);
    wait_done(dn, 50);
    chk("t2_beats", beat_cnt, 4);
    chk("t2_last_count", last_cnt, 1);

    // 16 words with m_ready pattern 1,0,0,1
    dn = done_cnt;
    send_cmd(10'h200, 11'd16);
    c = 0;
    while (done_cnt == dn && c < 400) begin
      m_ready = pat[c % 4];
      step();
      c++;
    end
    m_ready = 1'b1;
    wait_done(dn, 10);
    chk("t3_beats", beat_cnt, 16);
    chk("t3_last_count", last_cnt, 1);
`ifdef BRAM_RD_STALL_CNT_EN
    chk("t3_stall_cnt", stall_cnt, stall_seen);
`else
    chk("t3_stall_cnt_tied", stall_cnt, 0);
`endif

    // Zero-length command
    dn = done_cnt;
    send_cmd(10'h155, 11'd0);
    chk("t4_mem_en_c1", mem_en, 0);
    chk("t4_done_c1", done, 0);
    step();
    chk("t4_mem_en_c2", mem_en, 0);
    chk("t4_done_c2", done, 1);
    step();
    chk("t4_done_c3", done, 0);
    chk("t4_mem_en_c3", mem_en, 0);
    chk("t4_m_valid", m_valid, 0);
    chk("t4_done_once", done_cnt - dn, 1);
    chk("t4_beats", beat_cnt, 0);

    // Full 1024-word burst with a 20-cycle consumer stall
    dn = done_cnt;
    send_cmd(10'h000, 11'd1024);
    c = 0;
    while (beat_cnt < 100 && c < 400) begin
      step();
      c++;
    end
    chk("t5_reached_beat_100", 128'(beat_cnt >= 100), 1);
    m_ready = 1'b0;
    repeat (20) step();
    m_ready = 1'b1;
    wait_done(dn, 2000);
    chk("t5_beats", beat_cnt, 1024);
    chk("t5_last_count", last_cnt, 1);

    // Reset mid-burst at beat 5 of 32
    dn = done_cnt;
    send_cmd(10'h040, 11'd32);
    c = 0;
    while (beat_cnt < 5 && c < 50) begin
      step();
      c++;
    end
    chk("t6_reached_beat_5", 128'(beat_cnt >= 5), 1);
    #2 rst = 1'b1;
    #1;
    chk("t6_rst_mem_en", mem_en, 0);
    chk("t6_rst_m_valid", m_valid, 0);
    chk("t6_rst_m_last", m_last, 0);
    chk("t6_rst_m_data", m_data, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_mem_addr", mem_addr, 0);
    chk("t6_rst_done", done, 0);
    chk("t6_rst_stall_cnt", stall_cnt, 0);
    expq.delete();
    dc = done_cnt;
    lc = last_cnt;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) step();
    chk("t6_no_done_after_abort", done_cnt - dc, 0);
    chk("t6_no_partial_last", last_cnt - lc, 0);
    chk("t6_idle_valid", m_valid, 0);
    dn = done_cnt;
    send_cmd(10'h100, 11'd2);
    wait_done(dn, 50);
    chk("t6_beats_after_rst", beat_cnt, 2);
    chk("t6_last_after_rst", last_cnt, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
